// File: rtl/udp_rx_chan_packer_if.sv
// Bus bundle between the UDP receive core, the channel packer and the application.
// The packer sits on the slave modport; the surrounding source/sink side uses master.
interface udp_rx_chan_packer_if #(
   parameter int DATA_W = 64,
   parameter int NUM_CH = 4
);
   localparam int BPW  = DATA_W / 8;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              rx_udp_hdr_valid;
   logic              rx_udp_hdr_ready;
   logic [31:0]       rx_udp_ip_source_ip;
   logic [31:0]       rx_udp_ip_dest_ip;
   logic [15:0]       rx_udp_source_port;
   logic [15:0]       rx_udp_dest_port;

   logic [7:0]        rx_udp_payload_axis_tdata;
   logic              rx_udp_payload_axis_tvalid;
   logic              rx_udp_payload_axis_tready;
   logic              rx_udp_payload_axis_tlast;
   logic              rx_udp_payload_axis_tuser;

   logic [DATA_W-1:0] dout_data;
   logic [BPW-1:0]    dout_keep;
   logic              dout_valid;
   logic              dout_ready;
   logic              dout_last;
   logic              dout_user;
   logic [CH_W-1:0]   dout_ch;
   logic [31:0]       dout_src_ip;
   logic [15:0]       dout_src_port;

   modport master (
      output rx_udp_hdr_valid, rx_udp_ip_source_ip, rx_udp_ip_dest_ip,
             rx_udp_source_port, rx_udp_dest_port,
             rx_udp_payload_axis_tdata, rx_udp_payload_axis_tvalid,
             rx_udp_payload_axis_tlast, rx_udp_payload_axis_tuser, dout_ready,
      input  rx_udp_hdr_ready, rx_udp_payload_axis_tready,
             dout_data, dout_keep, dout_valid, dout_last, dout_user, dout_ch,
             dout_src_ip, dout_src_port
   );

   modport slave (
      input  rx_udp_hdr_valid, rx_udp_ip_source_ip, rx_udp_ip_dest_ip,
             rx_udp_source_port, rx_udp_dest_port,
             rx_udp_payload_axis_tdata, rx_udp_payload_axis_tvalid,
             rx_udp_payload_axis_tlast, rx_udp_payload_axis_tuser, dout_ready,
      output rx_udp_hdr_ready, rx_udp_payload_axis_tready,
             dout_data, dout_keep, dout_valid, dout_last, dout_user, dout_ch,
             dout_src_ip, dout_src_port
   );
endinterface

// File: rtl/udp_rx_chan_packer.sv
// UDP receive filter: maps a window of destination ports onto channels, packs payload
// bytes into DATA_W words with byte-enables, truncates oversize datagrams, counts drops/errors.
module udp_rx_chan_packer #(
   parameter int DATA_W    = 64,
   parameter int NUM_CH    = 4,
   parameter int MAX_BYTES = 1472,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   udp_rx_chan_packer_if.slave bus,
   input  logic [31:0]       local_ip,
   input  logic [31:0]       remote_ip,
   input  logic              src_ip_filter_en,
   input  logic [15:0]       port_base,
   input  logic [NUM_CH-1:0] ch_enable,
   output logic [CNT_W-1:0]  drop_count,
   output logic [CNT_W-1:0]  err_count
);
   localparam int BPW   = DATA_W / 8;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t            state, state_nxt;
   logic              run;
   logic              hdr_ready_c, tready_c;
   logic              hdr_hs, byte_hs;
   logic [16:0]       ch_diff;
   logic [CH_W-1:0]   ch_idx;
   logic              in_range, match;

   logic [CH_W-1:0]   ch_q;
   logic [31:0]       src_ip_q;
   logic [15:0]       src_port_q;
   logic [15:0]       byte_cnt, cnt_nxt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] acc, word_nxt;
   logic [BPW-1:0]    keep_nxt;
   logic              err_seen;
   logic              at_max, word_done, pkt_end, pkt_user;

   assign hdr_hs  = bus.rx_udp_hdr_valid && hdr_ready_c;
   assign byte_hs = bus.rx_udp_payload_axis_tvalid && tready_c;
   assign bus.rx_udp_hdr_ready           = hdr_ready_c;
   assign bus.rx_udp_payload_axis_tready = tready_c;

   // Port window check in 17 bits so ports below port_base go negative instead of wrapping.
   always_comb begin
      ch_diff  = {1'b0, bus.rx_udp_dest_port} - {1'b0, port_base};
      in_range = !ch_diff[16] && (ch_diff[15:0] < 16'(NUM_CH));
      ch_idx   = ch_diff[CH_W-1:0];
      match    = (bus.rx_udp_ip_dest_ip == local_ip) && in_range && ch_enable[ch_idx] &&
                 (!src_ip_filter_en || (bus.rx_udp_ip_source_ip == remote_ip));
   end

   // NOTE: every variable gets a default before any branch, so no path can infer a latch.
   always_comb begin
      cnt_nxt   = byte_cnt + 16'd1;
      at_max    = (cnt_nxt == 16'(MAX_BYTES));
      pkt_end   = bus.rx_udp_payload_axis_tlast || at_max;
      word_done = (idx == IDX_W'(BPW - 1)) || pkt_end;
      word_nxt  = acc | (DATA_W'(bus.rx_udp_payload_axis_tdata) << {idx, 3'b000});
      pkt_user  = err_seen || bus.rx_udp_payload_axis_tuser ||
                  (at_max && !bus.rx_udp_payload_axis_tlast);
      keep_nxt  = '0;
      for (int k = 0; k < BPW; k++) keep_nxt[k] = (k <= int'(idx));
   end

   // Ready depends only on registered state and dout_ready, never on tvalid/tlast.
   always_comb begin
      hdr_ready_c = 1'b0;
      tready_c    = 1'b0;
      if (rst_n && run) begin
         case (state)
            IDLE:    hdr_ready_c = 1'b1;
            PASS:    tready_c    = !bus.dout_valid || bus.dout_ready;
            DROP:    tready_c    = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (hdr_hs) state_nxt = match ? PASS : DROP;
         PASS: begin
            if (byte_hs && bus.rx_udp_payload_axis_tlast) state_nxt = IDLE;
            else if (byte_hs && at_max)                   state_nxt = DROP;
         end
         DROP: if (byte_hs && bus.rx_udp_payload_axis_tlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run               <= 1'b0;
         ch_q              <= '0;
         src_ip_q          <= '0;
         src_port_q        <= '0;
         byte_cnt          <= '0;
         idx               <= '0;
         acc               <= '0;
         err_seen          <= 1'b0;
         drop_count        <= '0;
         err_count         <= '0;
         bus.dout_valid    <= 1'b0;
         bus.dout_data     <= '0;
         bus.dout_keep     <= '0;
         bus.dout_last     <= 1'b0;
         bus.dout_user     <= 1'b0;
         bus.dout_ch       <= '0;
         bus.dout_src_ip   <= '0;
         bus.dout_src_port <= '0;
      end else begin
         run <= 1'b1;
         if (hdr_hs) begin
            if (match) begin
               ch_q       <= ch_idx;
               src_ip_q   <= bus.rx_udp_ip_source_ip;
               src_port_q <= bus.rx_udp_source_port;
               byte_cnt   <= '0;
               idx        <= '0;
               acc        <= '0;
               err_seen   <= 1'b0;
            end else if (drop_count != '1) begin
               drop_count <= drop_count + 1'b1;
            end
         end

         if (bus.dout_valid && bus.dout_ready) bus.dout_valid <= 1'b0;

         if (byte_hs && state == PASS) begin
            byte_cnt <= cnt_nxt;
            if (bus.rx_udp_payload_axis_tuser) err_seen <= 1'b1;
            if (word_done) begin
               // Overwrites the word being taken this cycle, so there is no bubble.
               acc               <= '0;
               idx               <= '0;
               bus.dout_valid    <= 1'b1;
               bus.dout_data     <= word_nxt;
               bus.dout_keep     <= keep_nxt;
               bus.dout_last     <= pkt_end;
               bus.dout_user     <= pkt_end && pkt_user;
               bus.dout_ch       <= ch_q;
               bus.dout_src_ip   <= src_ip_q;
               bus.dout_src_port <= src_port_q;
               if (pkt_end && pkt_user && err_count != '1) err_count <= err_count + 1'b1;
            end else begin
               acc <= word_nxt;
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_udp_rx_chan_packer.sv
// Directed bench for udp_rx_chan_packer: scoreboard of expected words, checked on the falling edge.
// dut_a runs with MAX_BYTES=16, dut_b with MAX_BYTES=1472 for the back-pressure scenario.
module tb_udp_rx_chan_packer;
   localparam int DATA_W = 64;
   localparam int NUM_CH = 4;
   localparam int BPW    = DATA_W / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, sel, rand_ready, stall_seen;
   logic        hdr_valid, tvalid, tlast, tuser, dout_ready;
   logic [31:0] sip, dip, local_ip, remote_ip;
   logic [15:0] sport, dport, port_base;
   logic [7:0]  tdata;
   logic        filter_en;
   logic [3:0]  ch_enable;
   logic [15:0] drop_a, err_a, drop_b, err_b;
   int          errors = 0;
   int          checks = 0;

   udp_rx_chan_packer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus_a ();
   udp_rx_chan_packer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus_b ();

   assign bus_a.rx_udp_hdr_valid           = hdr_valid;
   assign bus_a.rx_udp_ip_source_ip        = sip;
   assign bus_a.rx_udp_ip_dest_ip          = dip;
   assign bus_a.rx_udp_source_port         = sport;
   assign bus_a.rx_udp_dest_port           = dport;
   assign bus_a.rx_udp_payload_axis_tdata  = tdata;
   assign bus_a.rx_udp_payload_axis_tvalid = tvalid;
   assign bus_a.rx_udp_payload_axis_tlast  = tlast;
   assign bus_a.rx_udp_payload_axis_tuser  = tuser;
   assign bus_a.dout_ready                 = sel ? 1'b1 : dout_ready;
   assign bus_b.rx_udp_hdr_valid           = hdr_valid;
   assign bus_b.rx_udp_ip_source_ip        = sip;
   assign bus_b.rx_udp_ip_dest_ip          = dip;
   assign bus_b.rx_udp_source_port         = sport;
   assign bus_b.rx_udp_dest_port           = dport;
   assign bus_b.rx_udp_payload_axis_tdata  = tdata;
   assign bus_b.rx_udp_payload_axis_tvalid = tvalid;
   assign bus_b.rx_udp_payload_axis_tlast  = tlast;
   assign bus_b.rx_udp_payload_axis_tuser  = tuser;
   assign bus_b.dout_ready                 = sel ? dout_ready : 1'b1;

   logic        hdr_ready_s, tready_s, valid_s, last_s, user_s;
   logic [63:0] data_s;
   logic [7:0]  keep_s;
   logic [1:0]  ch_s;
   logic [31:0] sip_s;
   logic [15:0] sport_s;
   assign hdr_ready_s = sel ? bus_b.rx_udp_hdr_ready : bus_a.rx_udp_hdr_ready;
   assign tready_s    = sel ? bus_b.rx_udp_payload_axis_tready : bus_a.rx_udp_payload_axis_tready;
   assign valid_s     = sel ? bus_b.dout_valid    : bus_a.dout_valid;
   assign data_s      = sel ? bus_b.dout_data     : bus_a.dout_data;
   assign keep_s      = sel ? bus_b.dout_keep     : bus_a.dout_keep;
   assign last_s      = sel ? bus_b.dout_last     : bus_a.dout_last;
   assign user_s      = sel ? bus_b.dout_user     : bus_a.dout_user;
   assign ch_s        = sel ? bus_b.dout_ch       : bus_a.dout_ch;
   assign sip_s       = sel ? bus_b.dout_src_ip   : bus_a.dout_src_ip;
   assign sport_s     = sel ? bus_b.dout_src_port : bus_a.dout_src_port;

   udp_rx_chan_packer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_BYTES(16), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .local_ip(local_ip), .remote_ip(remote_ip),
      .src_ip_filter_en(filter_en), .port_base(port_base), .ch_enable(ch_enable),
      .drop_count(drop_a), .err_count(err_a));

   udp_rx_chan_packer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_BYTES(1472), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .local_ip(local_ip), .remote_ip(remote_ip),
      .src_ip_filter_en(filter_en), .port_base(port_base), .ch_enable(ch_enable),
      .drop_count(drop_b), .err_count(err_b));

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic [1:0]  ch;
      logic [31:0] sip;
      logic [15:0] sport;
   } word_t;

   word_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected words for a datagram of n bytes start, start+1, ...; complete=0 means no tlast sent.
   task automatic push_pkt(input int n, input logic [7:0] start, input int maxb, input logic [1:0] ch,
                           input logic [31:0] s_ip, input logic [15:0] s_port,
                           input logic user_last, input logic complete);
      word_t w;
      int    fwd  = (n > maxb) ? maxb : n;
      int    slot = 0;
      w = '{data: '0, keep: '0, last: 1'b0, user: 1'b0, ch: ch, sip: s_ip, sport: s_port};
      for (int i = 0; i < fwd; i++) begin
         w.data[8*slot +: 8] = start + 8'(i);
         w.keep[slot]        = 1'b1;
         slot++;
         if (slot == BPW || ((complete || n > maxb) && i == fwd - 1)) begin
            w.last = (complete || n > maxb) && (i == fwd - 1);
            w.user = w.last && ((n > maxb) || user_last);
            sb.push_back(w);
            w.data = '0;
            w.keep = '0;
            slot   = 0;
         end
      end
   endtask

   task automatic send_hdr(input logic [15:0] d_port, input logic [31:0] d_ip,
                           input logic [31:0] s_ip, input logic [15:0] s_port);
      logic done = 1'b0;
      dport = d_port; dip = d_ip; sip = s_ip; sport = s_port; hdr_valid = 1'b1;
      for (int g = 0; g < 100 && !done; g++) begin
         @(negedge clk);
         done = hdr_ready_s;
         @(posedge clk); #1;
         if (rand_ready) dout_ready = ($urandom_range(0, 99) >= 30);
      end
      hdr_valid = 1'b0;
      check("hdr_handshake", done, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
      logic done = 1'b0;
      tdata = d; tlast = l; tuser = u; tvalid = 1'b1;
      for (int g = 0; g < 100 && !done; g++) begin
         @(negedge clk);
         if (!tready_s) stall_seen = 1'b1;
         done = tready_s;
         @(posedge clk); #1;
         if (rand_ready) dout_ready = ($urandom_range(0, 99) >= 30);
      end
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      if (!done) check("byte_timeout", done, 1'b1);
   endtask

   task automatic send_pkt(input logic [15:0] d_port, input logic [31:0] d_ip, input logic [31:0] s_ip,
                           input logic [15:0] s_port, input int n, input logic [7:0] start,
                           input logic user_last, input logic with_last);
      send_hdr(d_port, d_ip, s_ip, s_port);
      stall_seen = 1'b0;
      for (int i = 0; i < n; i++)
         send_byte(start + 8'(i), with_last && (i == n - 1), user_last && (i == n - 1));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic settle(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; rand_ready = 1'b0; stall_seen = 1'b0;
      hdr_valid = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0;
      dout_ready = 1'b1; sip = '0; dip = '0; sport = '0; dport = '0;
      local_ip = 32'hC0A8010A; remote_ip = 32'hC0A80102; filter_en = 1'b1;
      port_base = 16'd5000; ch_enable = 4'b1111;

      fork
         begin : monitor
            word_t exp_w, saved;
            logic  held = 1'b0;
            forever begin
               @(negedge clk);
               if (!rst_n) held = 1'b0;
               else begin
                  if (held) begin
                     check("stall_valid", valid_s, 1'b1);
                     check("stall_data", data_s, saved.data);
                     check("stall_keep", keep_s, saved.keep);
                     check("stall_ch", ch_s, saved.ch);
                     check("stall_last", last_s, saved.last);
                  end
                  held = 1'b0;
                  if (valid_s && dout_ready) begin
                     if (sb.size() == 0) check("unexpected_word", valid_s, 1'b0);
                     else begin
                        exp_w = sb.pop_front();
                        check("word_data", data_s, exp_w.data);
                        check("word_keep", keep_s, exp_w.keep);
                        check("word_last", last_s, exp_w.last);
                        check("word_user", user_s, exp_w.user);
                        check("word_ch", ch_s, exp_w.ch);
                        check("word_src_ip", sip_s, exp_w.sip);
                        check("word_src_port", sport_s, exp_w.sport);
                     end
                  end else if (valid_s) begin
                     held  = 1'b1;
                     saved = '{data: data_s, keep: keep_s, last: last_s, user: user_s,
                               ch: ch_s, sip: sip_s, sport: sport_s};
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hdr_ready", hdr_ready_s, 1'b0);
      check("rst_tready", tready_s, 1'b0);
      check("rst_valid", valid_s, 1'b0);
      check("rst_data", data_s, 64'd0);
      check("rst_drop", drop_a, 16'd0);
      check("rst_err", err_a, 16'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rel_hdr_ready_0", hdr_ready_s, 1'b0);
      @(negedge clk);
      check("rel_hdr_ready_1", hdr_ready_s, 1'b1);
      @(posedge clk); #1;

      // 1: 10 bytes to port 5002
      push_pkt(10, 8'h00, 16, 2'd2, remote_ip, 16'd1234, 1'b0, 1'b1);
      send_pkt(16'd5002, local_ip, remote_ip, 16'd1234, 10, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check("t1_latency_valid", valid_s, 1'b1);
      check("t1_latency_last", last_s, 1'b1);
      settle("t1_sb_empty");

      // 2: four rejected headers, then the foreign source accepted with the filter off
      send_pkt(16'd4999, local_ip, remote_ip, 16'd1, 5, 8'h20, 1'b0, 1'b1);
      check("t2_tready_4999", stall_seen, 1'b0);
      send_pkt(16'd5004, local_ip, remote_ip, 16'd1, 5, 8'h20, 1'b0, 1'b1);
      check("t2_tready_5004", stall_seen, 1'b0);
      send_pkt(16'd5001, 32'hC0A8010B, remote_ip, 16'd1, 5, 8'h20, 1'b0, 1'b1);
      check("t2_tready_dst_ip", stall_seen, 1'b0);
      send_pkt(16'd5001, local_ip, 32'hC0A80199, 16'd1, 5, 8'h20, 1'b0, 1'b1);
      check("t2_tready_src_ip", stall_seen, 1'b0);
      settle("t2_no_output");
      check("t2_drop_count", drop_a, 16'd4);
      filter_en = 1'b0;
      push_pkt(5, 8'h30, 16, 2'd1, 32'hC0A80199, 16'd77, 1'b0, 1'b1);
      send_pkt(16'd5001, local_ip, 32'hC0A80199, 16'd77, 5, 8'h30, 1'b0, 1'b1);
      filter_en = 1'b1;
      settle("t2_filter_off");

      // 3: 20 bytes truncated to 16
      push_pkt(20, 8'h40, 16, 2'd0, remote_ip, 16'd999, 1'b0, 1'b1);
      send_pkt(16'd5000, local_ip, remote_ip, 16'd999, 20, 8'h40, 1'b0, 1'b1);
      @(negedge clk);
      check("t3_hdr_ready_after", hdr_ready_s, 1'b1);
      settle("t3_sb_empty");
      check("t3_err_count", err_a, 16'd1);
      check("t3_drop_count", drop_a, 16'd4);

      // 4: bad-frame flag on the last byte
      pulse_reset();
      push_pkt(8, 8'h60, 16, 2'd3, remote_ip, 16'd42, 1'b1, 1'b1);
      send_pkt(16'd5003, local_ip, remote_ip, 16'd42, 8, 8'h60, 1'b1, 1'b1);
      settle("t4_sb_empty");
      check("t4_err_count", err_a, 16'd1);

      // 6: reset in the middle of the second word
      push_pkt(11, 8'h70, 16, 2'd3, remote_ip, 16'd5, 1'b0, 1'b0);
      send_pkt(16'd5003, local_ip, remote_ip, 16'd5, 11, 8'h70, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_hdr_ready", hdr_ready_s, 1'b0);
      check("t6_rst_tready", tready_s, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("t6_valid", valid_s, 1'b0);
      check("t6_data", data_s, 64'd0);
      check("t6_keep", keep_s, 8'd0);
      check("t6_ch", ch_s, 2'd0);
      check("t6_src_ip", sip_s, 32'd0);
      check("t6_err", err_a, 16'd0);
      @(posedge clk); #1;
      push_pkt(10, 8'h90, 16, 2'd1, remote_ip, 16'd6, 1'b0, 1'b1);
      send_pkt(16'd5001, local_ip, remote_ip, 16'd6, 10, 8'h90, 1'b0, 1'b1);
      settle("t6_sb_empty");

      // 5: random back-pressure on back-to-back 24-byte datagrams, MAX_BYTES=1472
      pulse_reset();
      sel = 1'b1;
      rand_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         logic [15:0] pt = (p % 2 == 0) ? 16'd5001 : 16'd5003;
         logic [7:0]  st = 8'h10 + 8'(p * 48);
         push_pkt(24, st, 1472, 2'(pt - 16'd5000), remote_ip, 16'(100 + p), 1'b0, 1'b1);
         send_pkt(pt, local_ip, remote_ip, 16'(100 + p), 24, st, 1'b0, 1'b1);
      end
      for (int c = 0; c < 300 && sb.size() != 0; c++) begin
         @(posedge clk); #1;
         dout_ready = ($urandom_range(0, 99) >= 30);
      end
      rand_ready = 1'b0;
      dout_ready = 1'b1;
      settle("t5_drained");
      check("t5_drop_count", drop_b, 16'd0);
      check("t5_err_count", err_b, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
